dmem_access_ctrl: RTL

//  Sequences MEM-stage data-memory accesses of the 5-stage core against a variable-latency data memory.

---
 rtl/dmem_access_ctrl_pkg.sv | 16 +
 rtl/dmem_access_ctrl_timeout_cnt.sv | 18 +
 rtl/dmem_access_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg: shared widths and FSM state encoding for the MEM-stage access controller
`ifndef DATA_MEM_ADDR_BITS
`define DATA_MEM_ADDR_BITS 13
`endif
`ifndef INTERNAL_BITS
`define INTERNAL_BITS 32
`endif
package dmem_access_ctrl_pkg;
  localparam int DMEM_ADDR_W = `DATA_MEM_ADDR_BITS;
  localparam int DMEM_DATA_W = `INTERNAL_BITS;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_access_ctrl_timeout_cnt.sv
// dmem_timeout_cnt: REQ-cycle counter that flags the last cycle allowed before an access is aborted
module dmem_timeout_cnt #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  assign o_hit = r_cnt == CW'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences MEM-stage loads/stores as req/ack transactions and stalls the pipeline meanwhile
// Optional access-timeout abort enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_o,
  output logic              wb_en_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o
);
  state_t            r_state;
  logic              r_req, r_we, r_kill;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic              w_idle, w_start, w_to;
  assign w_idle  = (r_state == ST_IDLE) & ~rst;
  assign w_start = w_idle & op_valid & (mem_read | mem_write) & ~flush;
`ifdef DMEM_TIMEOUT_EN
  logic w_hit, r_err;
  dmem_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_start),
    .i_en  ((r_state == ST_REQ) & ~dmem_ack),
    .o_hit (w_hit)
  );
  assign w_to = (r_state == ST_REQ) & ~dmem_ack & w_hit;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_err <= 1'b0;
    else if (w_to) r_err <= 1'b1;
  assign err_o = r_err;
`else
  assign w_to  = 1'b0;
  assign err_o = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_kill  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE:
          if (w_start) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
            r_we    <= mem_write;
            r_kill  <= 1'b0;
            r_addr  <= addr_in;
            r_wdata <= wdata_in;
          end
        ST_REQ: begin
          // A flushed access still runs to completion; only its writeback is dropped.
          if (flush) r_kill <= 1'b1;
          if (dmem_ack) begin
            r_state <= ST_DONE;
            r_req   <= 1'b0;
            if (!r_we) r_rdata <= dmem_rdata;
          end else if (w_to) begin
            r_state <= ST_DONE;
            r_req   <= 1'b0;
            r_kill  <= 1'b1;
            r_rdata <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign rdata_o    = r_rdata;
  assign stall_o    = w_start | (r_state == ST_REQ);
  assign wb_en_o    = (w_idle & op_valid & ~mem_read & ~mem_write & ~flush)
                    | ((r_state == ST_DONE) & ~r_kill & ~flush & ~rst);
endmodule
